// File: rtl/serial_to_parallel_mlane.sv
// serial_to_parallel_mlane: multi-lane bit-serial to word deserializer with FWFT output FIFO.
// Optional idle auto-flush of partial words when S2P_IDLE_FLUSH_EN is defined.
module serial_to_parallel_mlane #(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 1,
  parameter int MSB_FIRST    = 0,
  parameter int FIFO_DEPTH   = 2,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [LANES-1:0]      in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_partial,
  output logic                  overflow,
  output logic                  busy
);
  localparam int N = DATA_WIDTH / LANES;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  logic [CW-1:0] k, slot;
  logic [DATA_WIDTH-1:0] asm_q, word;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [FIFO_DEPTH-1:0] mem_p;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic flush, complete, tag, pop, full, push;
`ifdef S2P_IDLE_FLUSH_EN
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  logic [TW-1:0] idle;
  assign flush = busy && !in_valid && idle == TW'(IDLE_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) idle <= '0;
    else idle <= (busy && !in_valid && !flush) ? idle + 1'b1 : '0;
`else
  assign flush = 1'b0;
`endif
  // each beat lands in its own slot; unwritten slots stay zero because asm_q clears per word
  always_comb begin
    slot = MSB_FIRST != 0 ? LAST - k : k;
    word = in_valid ? asm_q | (DATA_WIDTH'(in_data) << (slot * LANES)) : asm_q;
    complete = (in_valid && (k == LAST || in_last)) || flush;
    tag = flush || k != LAST;
  end
  assign busy = k != '0;
  assign out_valid = cnt != '0;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign pop = out_valid && out_ready;
  assign push = complete && (!full || pop);
  assign overflow = complete && full && !pop;
  assign out_data = mem[rd_ptr];
  assign out_partial = mem_p[rd_ptr];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      k <= '0;
      asm_q <= '0;
      mem <= '0;
      mem_p <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      k <= complete ? '0 : in_valid ? k + 1'b1 : k;
      asm_q <= complete ? '0 : word;
      if (push) begin
        mem[wr_ptr] <= word;
        mem_p[wr_ptr] <= tag;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: tb/tb_serial_to_parallel_mlane.sv
// tb_serial_to_parallel_mlane: directed checks of an LSB-first and an MSB-first 8-bit, 2-lane deserializer.
module tb_serial_to_parallel_mlane;
  logic clk, rstn, in_valid, in_last, out_ready;
  logic [1:0] in_data;
  logic ov0, op0, ovf0, bz0, ov1, op1, ovf1, bz1;
  logic [7:0] od0, od1;
  int n_chk = 0, n_err = 0;
  serial_to_parallel_mlane #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(0), .FIFO_DEPTH(2), .IDLE_TIMEOUT(16)) u0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_partial(op0), .overflow(ovf0), .busy(bz0));
  serial_to_parallel_mlane #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(1), .FIFO_DEPTH(2), .IDLE_TIMEOUT(16)) u1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_partial(op1), .overflow(ovf1), .busy(bz1));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic [1:0] d, input logic l);
    in_valid = 1;
    in_data = d;
    in_last = l;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic send_word(input logic [7:0] w, input logic rdy_last, input logic ov_exp);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data = w[2*i +: 2];
      in_last = 0;
      if (i == 3) begin
        out_ready = rdy_last;
        #2;
        chk("overflow_on_complete", ovf0, ov_exp);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rstn = 0; in_valid = 0; in_last = 0; in_data = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ov0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_data", od0, 0);
    chk("rst_ovf", ovf0, 0);
    rstn = 1;
    @(posedge clk);
    #1;
    out_ready = 1;
    beat(2'b01, 0); beat(2'b10, 0); beat(2'b11, 0);
    chk("t1_not_yet", ov0, 0);
    chk("t1_busy", bz0, 1);
    beat(2'b00, 0);
    chk("t1_valid", ov0, 1);
    chk("t1_data", od0, 8'h39);
    chk("t1_partial", op0, 0);
    chk("t2_data_msb", od1, 8'h6C);
    chk("t2_partial_msb", op1, 0);
    chk("t1_busy_clear", bz0, 0);
    @(posedge clk);
    #1;
    chk("t1_one_cycle", ov0, 0);
    beat(2'b11, 0); beat(2'b01, 1);
    chk("t3_valid", ov0, 1);
    chk("t3_data", od0, 8'h07);
    chk("t3_partial", op0, 1);
    chk("t3_busy", bz0, 0);
    chk("t3_data_msb", od1, 8'hD0);
    beat(2'b00, 0); beat(2'b01, 0); beat(2'b10, 0); beat(2'b11, 0);
    chk("t3_next_data", od0, 8'hE4);
    chk("t3_next_partial", op0, 0);
    @(posedge clk);
    #1;
    beat(2'b01, 0);
    in_last = 1;
    @(posedge clk);
    #1;
    in_last = 0;
    chk("lone_last_valid", ov0, 0);
    chk("lone_last_busy", bz0, 1);
    beat(2'b10, 0); beat(2'b11, 0); beat(2'b00, 0);
    chk("lone_last_data", od0, 8'h39);
    chk("lone_last_partial", op0, 0);
    @(posedge clk);
    #1;
    out_ready = 0;
    send_word(8'h11, 0, 0);
    send_word(8'h22, 0, 0);
    send_word(8'h33, 0, 1);
    chk("t4_ovf_pulse", ovf0, 0);
    @(posedge clk);
    #1;
    chk("t4_stable", od0, 8'h11);
    out_ready = 1;
    #1;
    chk("t4_head0", od0, 8'h11);
    @(posedge clk);
    #1;
    chk("t4_head1", od0, 8'h22);
    @(posedge clk);
    #1;
    chk("t4_empty", ov0, 0);
    out_ready = 0;
    send_word(8'h44, 0, 0);
    send_word(8'h55, 0, 0);
    send_word(8'h66, 1, 0);
    out_ready = 1;
    #1;
    chk("t5_head0", od0, 8'h55);
    @(posedge clk);
    #1;
    chk("t5_head1", od0, 8'h66);
    chk("t5_valid1", ov0, 1);
    @(posedge clk);
    #1;
    chk("t5_empty", ov0, 0);
    out_ready = 0;
    send_word(8'h77, 0, 0);
    beat(2'b01, 0); beat(2'b01, 0);
    chk("t6_pre_valid", ov0, 1);
    chk("t6_pre_busy", bz0, 1);
    rstn = 0;
    #2;
    chk("t6_rst_valid", ov0, 0);
    chk("t6_rst_busy", bz0, 0);
    @(posedge clk);
    #1;
    rstn = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_post_valid", ov0, 0);
    chk("t6_post_busy", bz0, 0);
`ifdef S2P_IDLE_FLUSH_EN
    out_ready = 1;
    beat(2'b11, 0); beat(2'b10, 0);
    repeat (15) @(posedge clk);
    #1;
    chk("idle_not_yet", ov0, 0);
    @(posedge clk);
    #1;
    chk("idle_valid", ov0, 1);
    chk("idle_data", od0, 8'h0B);
    chk("idle_partial", op0, 1);
    chk("idle_data_msb", od1, 8'hE0);
    chk("idle_busy", bz0, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
